// File: rtl/mau_pkg.sv
// Shared encodings for the memory access unit: request sizes, FSM states, byte-lane masks.
package mau_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    localparam logic [3:0] LANE_NONE = 4'b0000;
    localparam logic [3:0] LANE_B0   = 4'b0001;
    localparam logic [3:0] LANE_HLO  = 4'b0011;
    localparam logic [3:0] LANE_HHI  = 4'b1100;
    localparam logic [3:0] LANE_ALL  = 4'b1111;

endpackage

// File: rtl/mau_lane_align.sv
// Byte-lane select generation for a request and lane extraction/extension for load data.
module mau_lane_align
    import mau_pkg::*;
(
    input  logic [1:0]  req_size,
    input  logic [1:0]  req_lo,
    output logic [1:0]  eff_size,
    output logic [1:0]  eff_lo,
    output logic [3:0]  sel,
    output logic        misaligned,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_lo,
    input  logic        ld_unsigned,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    // Offending low address bits are cleared; size 11 behaves as a word access.
    always_comb begin
        eff_size   = SZ_WORD;
        eff_lo     = 2'b00;
        sel        = LANE_ALL;
        misaligned = 1'b0;
        case (req_size)
            SZ_BYTE: begin
                eff_size = SZ_BYTE;
                eff_lo   = req_lo;
                sel      = LANE_B0 << req_lo;
            end
            SZ_HALF: begin
                eff_size   = SZ_HALF;
                eff_lo     = {req_lo[1], 1'b0};
                sel        = req_lo[1] ? LANE_HHI : LANE_HLO;
                misaligned = req_lo[0];
            end
            SZ_WORD: begin
                misaligned = (req_lo != 2'b00);
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

    // Right-justify the selected lane(s) then sign- or zero-extend.
    always_comb begin
        shifted = rdata >> {ld_lo, 3'b000};
        ld_data = shifted;
        case (ld_size)
            SZ_BYTE: ld_data = {{24{~ld_unsigned & shifted[7]}}, shifted[7:0]};
            SZ_HALF: ld_data = {{16{~ld_unsigned & shifted[15]}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding CPU load/store unit driving a word-addressed data memory.
// Optional feature: define MAU_MISALIGN_TRAP_EN to trap misaligned requests instead of aligning them.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_str,
    output logic              mem_ld,
    output logic [3:0]        mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

`ifdef MAU_MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    state_e      state;
    state_e      next_state;
    logic [1:0]  eff_size;
    logic [1:0]  eff_lo;
    logic [3:0]  lane_sel;
    logic        misaligned;
    logic [1:0]  ld_size;
    logic [1:0]  ld_lo;
    logic        ld_unsigned;
    logic [31:0] ld_data;
    logic        accept;
    logic        trap;
    logic        unused_addr_hi;

    assign accept         = req_valid & req_ready;
    assign trap           = misaligned & TRAP_EN;
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    mau_lane_align u_align (
        .req_size    (req_size),
        .req_lo      (req_addr[1:0]),
        .eff_size    (eff_size),
        .eff_lo      (eff_lo),
        .sel         (lane_sel),
        .misaligned  (misaligned),
        .ld_size     (ld_size),
        .ld_lo       (ld_lo),
        .ld_unsigned (ld_unsigned),
        .rdata       (mem_rdata),
        .ld_data     (ld_data)
    );

    // Next-state logic; unreachable encodings fall back to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = trap ? ST_RESP : ST_ACCESS;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_ACCESS: next_state = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    next_state = ST_IDLE;
                end else begin
                    next_state = ST_RESP;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State register, memory strobes and response registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state       <= ST_IDLE;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 32'h0000_0000;
            rsp_err     <= 1'b0;
            mem_str     <= 1'b0;
            mem_ld      <= 1'b0;
            mem_sel     <= LANE_NONE;
            mem_addr    <= '0;
            mem_wdata   <= 32'h0000_0000;
            ld_size     <= SZ_WORD;
            ld_lo       <= 2'b00;
            ld_unsigned <= 1'b0;
        end else begin
            state     <= next_state;
            req_ready <= (next_state == ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (accept && !trap) begin
                        mem_addr    <= req_addr[ADDR_W+1:2];
                        mem_wdata   <= req_wdata;
                        mem_sel     <= lane_sel;
                        mem_str     <= req_we;
                        mem_ld      <= ~req_we;
                        ld_size     <= eff_size;
                        ld_lo       <= eff_lo;
                        ld_unsigned <= req_unsigned;
                    end else if (accept) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 32'h0000_0000;
                    end
                end
                ST_ACCESS: begin
                    mem_str   <= 1'b0;
                    mem_ld    <= 1'b0;
                    mem_sel   <= LANE_NONE;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= mem_ld ? ld_data : 32'h0000_0000;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    mem_str   <= 1'b0;
                    mem_ld    <= 1'b0;
                    mem_sel   <= LANE_NONE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural lane-writing word memory.
module tb_mem_access_unit;

    localparam int ADDR_W = 20;

    logic              clk = 1'b0;
    logic              clr_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_str;
    logic              mem_ld;
    logic [3:0]        mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    rsp_t        sb_q[$];
    logic [31:0] mem [0:255];
    int          acc_cnt = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_str      (mem_str),
        .mem_ld       (mem_ld),
        .mem_sel      (mem_sel),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Low-aligned store data lands in the selected lanes, starting at the lowest one.
    function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [3:0] sel);
        logic [31:0] sh;
        logic [31:0] res;
        if (sel[0])      sh = wd;
        else if (sel[1]) sh = wd << 8;
        else if (sel[2]) sh = wd << 16;
        else             sh = wd << 24;
        res = old;
        for (int k = 0; k < 4; k++) begin
            if (sel[k]) res[8*k +: 8] = sh[8*k +: 8];
        end
        return res;
    endfunction

    assign mem_rdata = mem_ld ? mem[mem_addr[7:0]] : 32'h0000_0000;

    always @(posedge clk) begin
        if (mem_str) mem[mem_addr[7:0]] <= merge_store(mem[mem_addr[7:0]], mem_wdata, mem_sel);
        if (mem_str || mem_ld) acc_cnt <= acc_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_data, input logic exp_err, input logic exp_mem,
                           input logic [31:0] exp_maddr, input logic [3:0] exp_sel, input int stall);
        int   n;
        int   acc0;
        rsp_t exp;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_req_ready"}, {31'b0, req_ready}, 32'h1);
        acc0 = acc_cnt;
        sb_q.push_back('{err: exp_err, data: exp_data});
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFC; req_wdata = 32'hA5A5_A5A5;
        check_eq({tag, "_busy"}, {31'b0, req_ready}, 32'h0);
        if (exp_mem) begin
            check_eq({tag, "_mem_str"}, {31'b0, mem_str}, {31'b0, we});
            check_eq({tag, "_mem_ld"}, {31'b0, mem_ld}, {31'b0, ~we});
            check_eq({tag, "_mem_addr"}, {12'h0, mem_addr}, exp_maddr);
            check_eq({tag, "_mem_sel"}, {28'h0, mem_sel}, {28'h0, exp_sel});
            if (we) check_eq({tag, "_mem_wdata"}, mem_wdata, wdata);
        end else begin
            check_eq({tag, "_no_mem"}, {30'b0, mem_str, mem_ld}, 32'h0);
        end
        n = 0;
        while (!rsp_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_latency"}, 32'(n), exp_mem ? 32'd1 : 32'd0);
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            check_eq({tag, "_rdata"}, rsp_rdata, exp.data);
            check_eq({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp.err});
        end else begin
            check_eq({tag, "_sb_underflow"}, 32'h1, {31'b0, rsp_valid});
        end
        for (int i = 0; i < stall; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0040;
            @(posedge clk); #1;
            check_eq({tag, "_hold_valid"}, {31'b0, rsp_valid}, 32'h1);
            check_eq({tag, "_hold_rdata"}, rsp_rdata, exp.data);
            check_eq({tag, "_hold_err"}, {31'b0, rsp_err}, {31'b0, exp.err});
            check_eq({tag, "_hold_ready"}, {31'b0, req_ready}, 32'h0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_eq({tag, "_rsp_drop"}, {31'b0, rsp_valid}, 32'h0);
        check_eq({tag, "_idle_ready"}, {31'b0, req_ready}, 32'h1);
        check_eq({tag, "_acc_cnt"}, 32'(acc_cnt - acc0), exp_mem ? 32'd1 : 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 32'h0000_0000;
        mem[8] <= 32'hCAFE_F00D;
        clr_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
        #1;
        check_eq("rst_req_ready", {31'b0, req_ready}, 32'h0);
        check_eq("rst_rsp", {29'b0, rsp_valid, rsp_err, mem_str}, 32'h0);
        check_eq("rst_mem_ld_sel", {27'b0, mem_ld, mem_sel}, 32'h0);
        check_eq("rst_mem_addr", {12'h0, mem_addr}, 32'h0);
        check_eq("rst_mem_wdata", mem_wdata, 32'h0);
        check_eq("rst_rdata", rsp_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 check_eq("rst_hold_ready", {31'b0, req_ready}, 32'h0);
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rel_req_ready", {31'b0, req_ready}, 32'h1);

        run_req("st_w",   1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b1, 32'h4, 4'b1111, 0);
        run_req("ld_w",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b1, 32'h4, 4'b1111, 0);
        run_req("ld_hs",  1'b0, 2'b01, 1'b0, 32'h12, 32'h0,         32'hFFFF_DEAD, 1'b0, 1'b1, 32'h4, 4'b1100, 0);
        run_req("ld_hu",  1'b0, 2'b01, 1'b1, 32'h10, 32'h0,         32'h0000_BEEF, 1'b0, 1'b1, 32'h4, 4'b0011, 0);
        run_req("st_b",   1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_0080, 32'h0,         1'b0, 1'b1, 32'h4, 4'b1000, 0);
        run_req("ld_bs",  1'b0, 2'b00, 1'b0, 32'h13, 32'h0,         32'hFFFF_FF80, 1'b0, 1'b1, 32'h4, 4'b1000, 0);
        run_req("ld_bu",  1'b0, 2'b00, 1'b1, 32'h13, 32'h0,         32'h0000_0080, 1'b0, 1'b1, 32'h4, 4'b1000, 0);
        run_req("ld_b1u", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0,         32'h0000_00BE, 1'b0, 1'b1, 32'h4, 4'b0010, 0);
        run_req("ld_b2s", 1'b0, 2'b00, 1'b0, 32'h12, 32'h0,         32'hFFFF_FFAD, 1'b0, 1'b1, 32'h4, 4'b0100, 0);
`ifdef MAU_MISALIGN_TRAP_EN
        run_req("mis_w",  1'b0, 2'b10, 1'b0, 32'h11, 32'h0,         32'h0,         1'b1, 1'b0, 32'h4, 4'b1111, 0);
        run_req("mis_h",  1'b0, 2'b01, 1'b0, 32'h13, 32'h0,         32'h0,         1'b1, 1'b0, 32'h4, 4'b1100, 0);
        run_req("sz_ill", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0,         32'h0,         1'b1, 1'b0, 32'h4, 4'b1111, 0);
`else
        run_req("mis_w",  1'b0, 2'b10, 1'b0, 32'h11, 32'h0,         32'h80AD_BEEF, 1'b0, 1'b1, 32'h4, 4'b1111, 0);
        run_req("mis_h",  1'b0, 2'b01, 1'b0, 32'h13, 32'h0,         32'hFFFF_80AD, 1'b0, 1'b1, 32'h4, 4'b1100, 0);
        run_req("sz_ill", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0,         32'h80AD_BEEF, 1'b0, 1'b1, 32'h4, 4'b1111, 0);
`endif
        run_req("stall",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         32'h80AD_BEEF, 1'b0, 1'b1, 32'h4, 4'b1111, 5);
        check_eq("mem_after_stall", mem[4], 32'h80AD_BEEF);

        // Reset in the middle of a store's ACCESS cycle.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq("rs_mem_str_on", {31'b0, mem_str}, 32'h1);
        check_eq("rs_mem_addr", {12'h0, mem_addr}, 32'h8);
        #2 clr_n = 1'b0;
        #1;
        check_eq("rs_mem_str_off", {31'b0, mem_str}, 32'h0);
        check_eq("rs_mem_sel", {28'h0, mem_sel}, 32'h0);
        check_eq("rs_req_ready", {31'b0, req_ready}, 32'h0);
        check_eq("rs_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        #1 check_eq("rs_pre_edge_ready", {31'b0, req_ready}, 32'h0);
        @(posedge clk); #1;
        check_eq("rs_post_edge_ready", {31'b0, req_ready}, 32'h1);
        check_eq("rs_word_unchanged", mem[8], 32'hCAFE_F00D);
        repeat (3) @(posedge clk);
        #1 check_eq("rs_no_rsp", {31'b0, rsp_valid}, 32'h0);
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
